// File: rtl/seg_scan_ctrl.sv
// Memory-mapped seven-segment scan controller: CPU-writable digit registers
// multiplexed onto active-low anode/cathode lines with PWM, blink and blanking.
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 10000,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              we,
    input  logic              re,
    input  logic [4:0]        addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(DIGITS - 1);

    typedef enum logic [2:0] {
        REG_DATA0  = 3'd0,
        REG_DATA1  = 3'd1,
        REG_EN     = 3'd2,
        REG_DP     = 3'd3,
        REG_CTRL   = 3'd4,
        REG_STATUS = 3'd5
    } reg_sel_t;

    logic [31:0]         data0, data1;
    logic [DIGITS-1:0]   en, dp;
    logic [PWM_BITS-1:0] brightness;
    logic                blink_en;

    logic [PRE_W-1:0]    pre_cnt;
    logic [3:0]          idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;

    reg_sel_t            reg_addr;
    logic [31:0]         rd_data;
    logic                unused_addr_bits;
    logic [63:0]         data_all;
    logic [15:0]         en_full, dp_full;
    logic [3:0]          nibble;
    logic                lit;

    assign reg_addr         = reg_sel_t'(addr[4:2]);
    assign unused_addr_bits = ^addr[1:0];
    assign data_all         = {data1, data0};
    assign en_full          = 16'(en);
    assign dp_full          = 16'(dp);
    assign nibble           = data_all[{idx, 2'b00} +: 4];

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data0      <= '0;
            data1      <= '0;
            en         <= '1;
            dp         <= '0;
            brightness <= '1;
            blink_en   <= 1'b0;
        end else if (sel && we) begin
            case (reg_addr)
                REG_DATA0: data0 <= din;
                REG_DATA1: data1 <= din;
                REG_EN:    en    <= din[DIGITS-1:0];
                REG_DP:    dp    <= din[DIGITS-1:0];
                REG_CTRL: begin
                    brightness <= din[PWM_BITS-1:0];
                    blink_en   <= din[16];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr)
            REG_DATA0:  rd_data = data0;
            REG_DATA1:  rd_data = data1;
            REG_EN:     rd_data[DIGITS-1:0] = en;
            REG_DP:     rd_data[DIGITS-1:0] = dp;
            REG_CTRL: begin
                rd_data[PWM_BITS-1:0] = brightness;
                rd_data[16]           = blink_en;
            end
            REG_STATUS: begin
                rd_data[3:0] = idx;
                rd_data[16]  = blink_phase;
            end
            default: rd_data = '0;
        endcase
    end

    // Registered read port: a same-edge write is not visible until the next read.
    always_ff @(posedge clock) begin
        if (!reset_n)
            dout <= '0;
        else if (sel && re)
            dout <= rd_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    if (frame_cnt == FRM_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Slot cycle 0 stays dark so the previous digit's pattern never ghosts.
    assign lit = en_full[idx] && (pre_cnt != '0) && (pwm_cnt <= brightness)
                 && !(blink_en && blink_phase);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            an  <= '1;
            seg <= 8'hFF;
        end else if (lit) begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= ~{dp_full[idx], hex7(nibble)};
        end else begin
            an  <= '1;
            seg <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: an arithmetic time-based model feeds
// an expectation queue that is drained and compared every cycle.
module tb_seg_scan_ctrl;

    localparam int D  = 6;
    localparam int P  = 4;
    localparam int PB = 2;
    localparam int BF = 2;

    localparam logic [4:0] A_DATA0  = 5'h00;
    localparam logic [4:0] A_DATA1  = 5'h04;
    localparam logic [4:0] A_EN     = 5'h08;
    localparam logic [4:0] A_DP     = 5'h0C;
    localparam logic [4:0] A_CTRL   = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;

    logic          clock = 1'b0;
    logic          reset_n, sel, we, re;
    logic [4:0]    addr;
    logic [31:0]   din, dout;
    logic [D-1:0]  an;
    logic [7:0]    seg;

    always #5 clock = ~clock;

    seg_scan_ctrl #(
        .DIGITS(D), .PRESCALE(P), .PWM_BITS(PB), .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout), .an(an), .seg(seg)
    );

    typedef struct packed {
        logic [D-1:0] an;
        logic [7:0]   seg;
        logic [31:0]  dout;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    int           t;
    logic [31:0]  m_data0, m_data1, m_dout;
    logic [D-1:0] m_en, m_dp;
    logic [PB-1:0] m_bright;
    logic         m_blink;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    function automatic int modelIdx();
        return (t / P) % D;
    endfunction

    function automatic int modelPhase();
        return ((t / P) / D / BF) % 2;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a[4:2])
            3'd0: return m_data0;
            3'd1: return m_data1;
            3'd2: return 32'(m_en);
            3'd3: return 32'(m_dp);
            3'd4: return (32'(m_blink) << 16) | 32'(m_bright);
            3'd5: return (32'(modelPhase()) << 16) | 32'(modelIdx());
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        t        = 0;
        m_data0  = '0;
        m_data1  = '0;
        m_en     = '1;
        m_dp     = '0;
        m_bright = '1;
        m_blink  = 1'b0;
        m_dout   = '0;
    endtask

    // Drives one cycle: predicts the post-edge outputs, advances the model,
    // then samples the DUT on the falling edge.
    task automatic applyStimulus(input logic rst_n, input logic s, input logic w,
                                 input logic r, input logic [4:0] a, input logic [31:0] d);
        exp_t e, got;
        int idx, pwm;
        bit lit;
        logic [D-1:0] one_hot;
        logic [63:0] all_data;
        reset_n = rst_n; sel = s; we = w; re = r; addr = a; din = d;
        if (!rst_n) begin
            modelReset();
            e.an = '1; e.seg = 8'hFF; e.dout = 32'h0;
        end else begin
            idx      = modelIdx();
            pwm      = t % (1 << PB);
            all_data = {m_data1, m_data0};
            lit = m_en[idx] && (t % P != 0) && (pwm <= int'(m_bright))
                  && !(m_blink && modelPhase() == 1);
            one_hot = '0;
            one_hot[idx] = 1'b1;
            e.an  = lit ? ~one_hot : '1;
            e.seg = lit ? ~{m_dp[idx], hex_tab[all_data[idx*4 +: 4]]} : 8'hFF;
            if (s && r) m_dout = modelRead(a);
            e.dout = m_dout;
            if (s && w) begin
                case (a[4:2])
                    3'd0: m_data0 = d;
                    3'd1: m_data1 = d;
                    3'd2: m_en    = d[D-1:0];
                    3'd3: m_dp    = d[D-1:0];
                    3'd4: begin m_bright = d[PB-1:0]; m_blink = d[16]; end
                    default: ;
                endcase
            end
            t++;
        end
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        got.an = an; got.seg = seg; got.dout = dout;
        e = exp_q.pop_front();
        checkOutput("an",   32'(got.an),  32'(e.an));
        checkOutput("seg",  32'(got.seg), 32'(e.seg));
        checkOutput("dout", got.dout,     e.dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic readReg(input logic [4:0] a);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        modelReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
        idle(30);
        readReg(A_EN);
        readReg(A_CTRL);
        readReg(A_DATA0);

        writeReg(A_DP, 32'h15);
        for (int v = 0; v < 16; v++) begin
            writeReg(A_DATA0, {8{4'(v)}});
            idle(P * D);
        end

        writeReg(A_DATA0, 32'h9876543A);
        writeReg(A_DP, 32'h01);
        writeReg(A_EN, 32'h2B);
        readReg(A_DATA0);
        idle(50);
        writeReg(A_DATA1, 32'hCAFEF00D);
        readReg(A_DATA1);
        readReg(5'h01);

        writeReg(A_EN, 32'h3F);
        writeReg(A_CTRL, 32'h1);
        idle(40);
        writeReg(A_CTRL, 32'h0);
        idle(40);
        readReg(A_CTRL);

        writeReg(A_CTRL, 32'h0001_0003);
        for (int i = 0; i < 110; i++) readReg(A_STATUS);
        writeReg(A_CTRL, 32'h3);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, A_DP, 32'h3F);
        readReg(A_DP);
        writeReg(A_STATUS, 32'hFFFF_FFFF);
        writeReg(5'h18, 32'hFFFF_FFFF);
        writeReg(5'h1C, 32'hFFFF_FFFF);
        readReg(5'h18);
        readReg(5'h1C);
        readReg(A_STATUS);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, A_DATA0, 32'hDEADBEEF);
        readReg(A_DATA0);

        writeReg(A_DATA0, 32'h12345678);
        for (int i = 0; i < 30 && modelIdx() != 5; i++) idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
        readReg(A_DATA0);
        readReg(A_EN);
        idle(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
